shift_logical_right: RTL and testbench
======================================

SHIFT_LOGICAL_RIGHT -- requirements
Module: shift_logical_right

Interface
- Parameters: none; data width fixed at 64 bits, shift amount fixed at 6 bits.
- REQ-001: Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
- REQ-002: clk  input  1  rising-edge clock for all state.
- REQ-003: rst_n  input  1  asynchronous active-low reset.
- REQ-004: in_valid  input  1  qualifies a and b on the current edge.
- REQ-005: a  input  64  operand to shift.
- REQ-006: b  input  6  shift amount, unsigned 0..63.
- REQ-007: slr_ab  output  64  registered result of a logically shifted right by b.
- REQ-008: out_valid  output  1  high for one cycle when slr_ab holds a new result.

Function
- REQ-009: On a rising clk edge with in_valid=1, slr_ab SHALL load a >> b, with vacated MSBs zero-filled (logical, never sign-extended).
- REQ-010: Latency SHALL be exactly 1 cycle: the result of inputs sampled at edge N SHALL be visible after edge N.
- REQ-011: Throughput SHALL be one operation per cycle, with no stall or back-pressure.
- REQ-012: out_valid SHALL equal in_valid registered by one cycle.
- REQ-013: With in_valid=0, slr_ab SHALL hold its previous value and out_valid SHALL be 0 after the edge.
- REQ-014: The shifter SHALL be a 6-stage logarithmic barrel structure.
  - Stage k (k=0..5) SHALL shift by 2^k when b[k]=1 and pass through when b[k]=0.
  - Each stage SHALL insert zeros at the MSB end.
- REQ-015: b=0 SHALL pass a unchanged.
- REQ-016: b=63 SHALL yield {63'b0, a[63]}.
- REQ-017: No shift amount SHALL wrap or rotate; bits shifted out of bit 0 are discarded.
- REQ-018: The datapath SHALL be purely combinational between the input ports and the output register, with no internal state other than slr_ab and out_valid.
- REQ-019: X/Z on b while in_valid=0 SHALL NOT affect held outputs.

Reset
- REQ-020: While rst_n=0, slr_ab SHALL be 64'h0 and out_valid SHALL be 0, asynchronously and independent of clk.
- REQ-021: Reset asserted mid-operation SHALL discard the pending result; no out_valid pulse SHALL follow reset release without a new in_valid.
- REQ-022: The first edge after rst_n deasserts SHALL process inputs normally.

Verification
- REQ-023: a=64'h1234567890ABCDEF, b=0, in_valid=1 -> next cycle slr_ab=64'h1234567890ABCDEF, out_valid=1.
- REQ-024: Same a, b=1/4/8/16/32 -> slr_ab as follows:
  - b=1: 64'h091A2B3C4855E6F7
  - b=4: 64'h01234567890ABCDE
  - b=8: 64'h001234567890ABCD
  - b=16: 64'h00001234567890AB
  - b=32: 64'h0000000012345678
- REQ-025: Boundary cases at b=63:
  - a=64'h1 -> slr_ab=64'h0.
  - a=64'h8000000000000000 -> slr_ab=64'h1.
- REQ-026: a=64'hFEDCBA9876543210, b=45 -> slr_ab=64'h000000000007F6E5.
- REQ-027: a=64'hFFFFFFFFFFFFFFFF, b=0 -> slr_ab all ones; then in_valid=0 with a=0 -> slr_ab stays all ones and out_valid=0.
- REQ-028: Back-to-back inputs on consecutive cycles, with rst_n pulsed low mid-stream -> slr_ab=0 and out_valid=0 immediately; results resume on the cycle after new in_valid.

Source files
------------

// File: rtl/shift_logical_right.sv
// Registered 64-bit logical right shifter: six-stage log barrel datapath
// feeding a single result register with a one-cycle valid strobe.
module shift_logical_right (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [63:0] a,
    input  logic [5:0]  b,
    output logic [63:0] slr_ab,
    output logic        out_valid
);

    logic [63:0] stage_data [0:6];

    assign stage_data[0] = a;

    // Stage k shifts by 2^k when b[k] is set, zero-filling from the MSB end.
    for (genvar k = 0; k < 6; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign stage_data[k+1] = b[k] ? {{SH{1'b0}}, stage_data[k][63:SH]}
                                      : stage_data[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slr_ab    <= 64'h0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                slr_ab <= stage_data[6];
            end
        end
    end

endmodule

// File: tb/tb_shift_logical_right.sv
// Directed bench for shift_logical_right: arithmetic reference model checked
// every cycle, plus literal expectations on the hand-computed vectors.
module tb_shift_logical_right;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] a = 64'h0;
    logic [5:0]  b = 6'h0;
    logic [63:0] slr_ab;
    logic        out_valid;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] exp_slr = 64'h0;
    logic        exp_valid = 1'b0;

    shift_logical_right dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .slr_ab    (slr_ab),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: result is the plain arithmetic quotient a / 2^b, captured on valid edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_slr   = 64'h0;
            exp_valid = 1'b0;
        end else begin
            if (in_valid) exp_slr = a / (64'h1 << b);
            exp_valid = in_valid;
        end
    end

    always @(negedge clk) begin
        check("model_slr_ab", slr_ab, exp_slr);
        check("model_out_valid", {63'h0, out_valid}, {63'h0, exp_valid});
    end

    task automatic apply(input logic [63:0] av, input logic [5:0] bv,
                         input logic [63:0] expv, input string nm);
        @(negedge clk);
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        check(nm, slr_ab, expv);
        check({nm, "_valid"}, {63'h0, out_valid}, 64'h1);
    endtask

    task automatic idle_check(input logic [63:0] held, input string nm);
        @(negedge clk);
        in_valid = 1'b0;
        a = 64'h0;
        b = 6'bxxxxxx;
        @(posedge clk);
        #1;
        check(nm, slr_ab, held);
        check({nm, "_valid"}, {63'h0, out_valid}, 64'h0);
    endtask

    initial begin
        #2;
        check("reset_slr_ab", slr_ab, 64'h0);
        check("reset_out_valid", {63'h0, out_valid}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        apply(64'h1234567890ABCDEF, 6'd0,  64'h1234567890ABCDEF, "b0");
        apply(64'h1234567890ABCDEF, 6'd1,  64'h091A2B3C4855E6F7, "b1");
        apply(64'h1234567890ABCDEF, 6'd4,  64'h01234567890ABCDE, "b4");
        apply(64'h1234567890ABCDEF, 6'd8,  64'h001234567890ABCD, "b8");
        apply(64'h1234567890ABCDEF, 6'd16, 64'h00001234567890AB, "b16");
        apply(64'h1234567890ABCDEF, 6'd32, 64'h0000000012345678, "b32");
        apply(64'h0000000000000001, 6'd63, 64'h0000000000000000, "b63_lsb");
        apply(64'h8000000000000000, 6'd63, 64'h0000000000000001, "b63_msb");
        apply(64'hFEDCBA9876543210, 6'd45, 64'h000000000007F6E5, "b45");
        apply(64'hFFFFFFFFFFFFFFFF, 6'd0,  64'hFFFFFFFFFFFFFFFF, "ones_b0");
        idle_check(64'hFFFFFFFFFFFFFFFF, "hold_ones");
        idle_check(64'hFFFFFFFFFFFFFFFF, "hold_ones_x_b");
        apply(64'hFFFFFFFFFFFFFFFF, 6'd63, 64'h0000000000000001, "ones_b63");
        apply(64'hFFFFFFFFFFFFFFFF, 6'd7,  64'h01FFFFFFFFFFFFFF, "ones_b7");

        for (int i = 0; i < 6; i++) begin
            apply(64'hA5A5_0000_FFFF_1234, 6'(i * 11), 64'hA5A5_0000_FFFF_1234 >> (i * 11), "stream");
        end

        // Reset in the middle of a streaming input; pending result is dropped.
        @(negedge clk);
        in_valid = 1'b1;
        a = 64'hDEADBEEFCAFEF00D;
        b = 6'd3;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_slr_ab", slr_ab, 64'h0);
        check("midreset_out_valid", {63'h0, out_valid}, 64'h0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_no_pulse", {63'h0, out_valid}, 64'h0);
        check("post_reset_slr_ab", slr_ab, 64'h0);
        apply(64'hDEADBEEFCAFEF00D, 6'd4, 64'h0DEADBEEFCAFEF00, "resume");
        apply(64'hDEADBEEFCAFEF00D, 6'd60, 64'h000000000000000D, "resume_b60");
        idle_check(64'h000000000000000D, "final_hold");

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
